// File: rtl/axis_adc_sample_packer_pkg.sv
// Shared constants for the ADC sample packer slice.
// Sample/word widths, default sizing and the constant keep value.
package axis_adc_pkg;

  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;
  localparam int KEEP_W   = WORD_W / 8;

  localparam int DEF_WORDS_PER_PKT = 256;
  localparam int DEF_FIFO_DEPTH    = 512;

  localparam logic [KEEP_W-1:0] TKEEP_ALL = 4'hF;

endpackage

// File: rtl/axis_adc_sample_packer_if.sv
// AXI-Stream bundle used on both sides of the packer.
// Width parameters let one interface serve 16- and 32-bit links.
interface axis_adc_sample_packer_if #(
  parameter int DATA_W = 16,
  parameter int KEEP_W = 2
) ();

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [KEEP_W-1:0] tkeep;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tkeep,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tkeep,
    output tready
  );

endinterface

// File: rtl/axis_adc_sample_packer_fifo.sv
// First-word-fall-through synchronous FIFO for packed words.
// Pointers carry one extra wrap bit to tell full from empty.
module sync_fifo_fwft #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  // Head is shown as zero while empty so the bus idles clean.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; level follows from the registered pointers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array, no reset needed since empty masks stale data.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/axis_adc_sample_packer.sv
// Packs 16-bit ADC samples in pairs into 32-bit AXIS packets.
// Absorbs output stalls in a FIFO and counts samples it had to drop.
import axis_adc_pkg::*;

module axis_adc_sample_packer #(
  parameter  int WORDS_PER_PKT = DEF_WORDS_PER_PKT,
  parameter  int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter  int CNT_W         = 16,
  localparam int LW            = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  axis_adc_sample_packer_if.slave   s_axis,
  axis_adc_sample_packer_if.master  m_axis,
  output logic [LW-1:0]             fifo_level,
  output logic [CNT_W-1:0]          drop_count
);

  localparam int BW = $clog2(WORDS_PER_PKT);
  localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS_PER_PKT - 1);

  logic                half_valid;
  logic [SAMPLE_W-1:0] half_data;
  logic [BW-1:0]       beat_cnt;
  logic                fifo_full;
  logic                fifo_empty;
  logic                s_hs;
  logic                m_hs;
  logic                wr_en;
  logic [WORD_W-1:0]   wr_data;
  logic                unused_in;

  // Framing sideband from the ADC stage carries no meaning here.
  assign unused_in = ^{s_axis.tlast, s_axis.tkeep};

  assign s_axis.tready = resetn && !(half_valid && fifo_full);
  assign s_hs    = s_axis.tvalid && s_axis.tready;
  assign wr_en   = s_hs && half_valid;
  assign wr_data = {s_axis.tdata, half_data};

  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tlast  = (beat_cnt == LAST_BEAT);
  assign m_axis.tkeep  = TKEEP_ALL;
  assign m_hs = m_axis.tvalid && m_axis.tready;

  sync_fifo_fwft #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (m_hs),
    .rd_data (m_axis.tdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Low half holder: first sample of a pair waits here for its partner.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      half_valid <= 1'b0;
      half_data  <= '0;
    end else if (s_hs) begin
      half_valid <= !half_valid;
      if (!half_valid) half_data <= s_axis.tdata;
    end
  end

  // Beat position inside the current output packet.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      beat_cnt <= '0;
    end else if (m_hs) begin
      beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BW'(1);
    end
  end

  // Saturating count of samples offered while we could not take them.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      drop_count <= '0;
    end else if (s_axis.tvalid && !s_axis.tready && drop_count != '1) begin
      drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_adc_sample_packer.sv
// Bench for the sample packer: directed scenarios plus random traffic.
// A queue-based reference model predicts every output each cycle.
module tb_axis_adc_sample_packer;

  localparam int WPP   = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             resetn;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] drops;

  axis_adc_sample_packer_if #(.DATA_W(16), .KEEP_W(2)) s_if ();
  axis_adc_sample_packer_if #(.DATA_W(32), .KEEP_W(4)) m_if ();

  axis_adc_sample_packer #(
    .WORDS_PER_PKT (WPP),
    .FIFO_DEPTH    (DEPTH),
    .CNT_W         (CNT_W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .fifo_level (level),
    .drop_count (drops)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mdl_q[$];
  logic        mdl_hv;
  logic [15:0] mdl_lo;
  int          mdl_beat;
  int          mdl_drops;
  logic [32:0] seen[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_clear();
    mdl_q.delete();
    mdl_hv    = 1'b0;
    mdl_lo    = '0;
    mdl_beat  = 0;
    mdl_drops = 0;
  endtask

  task automatic cycle(input logic rn, input logic sv,
                       input logic [15:0] sd, input logic mr);
    logic        exp_rdy;
    logic [31:0] exp_data;
    logic        mhs;
    @(negedge clk);
    resetn      = rn;
    s_if.tvalid = sv;
    s_if.tdata  = sd;
    s_if.tlast  = 1'($urandom);
    s_if.tkeep  = 2'($urandom);
    m_if.tready = mr;
    #1;
    exp_rdy  = rn && !(mdl_hv && mdl_q.size() == DEPTH);
    exp_data = (mdl_q.size() != 0) ? mdl_q[0] : 32'h0;
    chk("s_tready", 32'(s_if.tready), 32'(exp_rdy));
    chk("m_tvalid", 32'(m_if.tvalid), 32'(mdl_q.size() != 0));
    chk("m_tdata", m_if.tdata, exp_data);
    chk("m_tlast", 32'(m_if.tlast), 32'(mdl_beat == WPP - 1));
    chk("m_tkeep", 32'(m_if.tkeep), 32'hF);
    chk("fifo_level", 32'(level), 32'(mdl_q.size()));
    chk("drop_count", 32'(drops), 32'(mdl_drops));
    mhs = mr && mdl_q.size() != 0;
    if (mhs) seen.push_back({m_if.tlast, m_if.tdata});
    if (!rn) begin
      mdl_clear();
    end else begin
      if (mhs) begin
        void'(mdl_q.pop_front());
        mdl_beat = (mdl_beat + 1) % WPP;
      end
      if (sv && exp_rdy) begin
        if (mdl_hv) mdl_q.push_back({sd, mdl_lo});
        else mdl_lo = sd;
        mdl_hv = !mdl_hv;
      end else if (sv) begin
        if (mdl_drops < (1 << CNT_W) - 1) mdl_drops++;
      end
    end
  endtask

  task automatic idle(input int n, input logic mr);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 16'h0, mr);
  endtask

  initial begin
    mdl_clear();
    resetn      = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    s_if.tkeep  = '0;
    m_if.tready = 1'b0;

    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);

    seen.delete();
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b1, 16'(i), 1'b1);
    idle(3, 1'b1);
    chk("pair_cnt", 32'(seen.size()), 32'd2);
    if (seen.size() == 2) begin
      chk("pair0", seen[0][31:0], 32'h0002_0001);
      chk("pair1", seen[1][31:0], 32'h0004_0003);
    end

    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    seen.delete();
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 16'($urandom), 1'b1);
    idle(4, 1'b1);
    chk("pkt_words", 32'(seen.size()), 32'd8);
    foreach (seen[i]) chk("pkt_tlast", 32'(seen[i][32]), 32'(i == 3 || i == 7));

    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 16'(i), 1'b0);
    idle(1, 1'b0);
    chk("full_level", 32'(level), 32'd4);
    chk("full_drops", 32'(drops), 32'd3);
    chk("full_rdy", 32'(s_if.tready), 32'd0);
    seen.delete();
    idle(4, 1'b1);
    chk("drain_cnt", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) begin
      chk("drain0", seen[0][31:0], 32'h0001_0000);
      chk("drain1", seen[1][31:0], 32'h0003_0002);
      chk("drain2", seen[2][31:0], 32'h0005_0004);
      chk("drain3", seen[3][31:0], 32'h0007_0006);
    end

    for (int i = 9; i <= 14; i++) cycle(1'b1, 1'b1, 16'(i), 1'b0);
    idle(1, 1'b0);
    chk("near_level", 32'(level), 32'd3);
    cycle(1'b1, 1'b1, 16'd15, 1'b1);
    idle(1, 1'b0);
    chk("rw_level", 32'(level), 32'd3);
    chk("rw_drops", 32'(drops), 32'd3);
    idle(6, 1'b1);

    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 16'($urandom), 1'b1);
    idle(2, 1'b1);
    cycle(1'b0, 1'b1, 16'h1234, 1'b1);
    idle(1, 1'b0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("rst_tdata", m_if.tdata, 32'd0);
    chk("rst_tlast", 32'(m_if.tlast), 32'd0);
    seen.delete();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 16'($urandom), 1'b1);
    idle(3, 1'b1);
    chk("rst_pkt", 32'(seen.size()), 32'd4);
    foreach (seen[i]) chk("rst_tl", 32'(seen[i][32]), 32'(i == 3));

    for (int i = 0; i < 29; i++) cycle(1'b1, 1'b1, 16'(i), 1'b0);
    idle(1, 1'b0);
    chk("sat_drops", 32'(drops), 32'hF);
    idle(6, 1'b1);

    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 9) < 7),
            16'($urandom),
            ($urandom_range(0, 9) < 6));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
